// File: rtl/timer_arbiter_pkg.sv
// Shared codes for the timer arbiter: interval codes, requester indices and FSM state encoding.
package timer_arbiter_pkg;

    localparam int unsigned INT_ARM_DELAY    = 0;
    localparam int unsigned INT_DRIVER_DELAY = 1;
    localparam int unsigned INT_PASS_DELAY   = 2;
    localparam int unsigned INT_ALARM_ON     = 3;

    localparam int unsigned REQ_MAIN  = 0;
    localparam int unsigned REQ_ARM   = 1;
    localparam int unsigned REQ_PUMP  = 2;
    localparam int unsigned REQ_SPARE = 3;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StLoad  = 3'd2,
        StRun   = 3'd3,
        StDone  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/timer_arbiter_if.sv
// Requester / parameter-table / timer signal bundle around the timer arbiter.
interface timer_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2,
    parameter int unsigned VAL_W = 4
) ();
    logic [NREQ-1:0]       req;
    logic [NREQ*IDX_W-1:0] req_idx;
    logic [NREQ-1:0]       cancel;
    logic [VAL_W-1:0]      param_value;
    logic                  timer_expired;
    logic [IDX_W-1:0]      interval;
    logic                  start_timer;
    logic [VAL_W-1:0]      load_value;
    logic [NREQ-1:0]       owner;
    logic [NREQ-1:0]       done;
    logic                  busy;

    // Environment side: requesters, parameter table and timer.
    modport master (
        output req, req_idx, cancel, param_value, timer_expired,
        input  interval, start_timer, load_value, owner, done, busy
    );

    modport slave (
        input  req, req_idx, cancel, param_value, timer_expired,
        output interval, start_timer, load_value, owner, done, busy
    );
endinterface

// File: rtl/timer_arbiter_prio_pick.sv
// Fixed-priority selector: lowest set bit wins; returns one-hot grant and its binary index.
module timer_arbiter_prio_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  vec,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] index,
    output logic          any
);

    always_comb begin
        onehot = '0;
        index  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                index     = IW'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/timer_arbiter.sv
// Shares one countdown timer and the time-parameter table between several sequencers.
// Optional TIMER_ARB_PREEMPT_EN: a higher-priority pending request aborts a lower-priority run.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2,
    parameter int unsigned VAL_W = 4
) (
    input logic            clock,
    input logic            reset,
    timer_arbiter_if.slave bus
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e       state_q, state_d;
    logic [NREQ-1:0]  pending_q, pending_d;
    logic [NREQ-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0] interval_q, interval_d;
    logic             first_q, first_d;
    logic [IDX_W-1:0] idx_q [NREQ];

    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [NREQ-1:0]  grant_clr;
    logic [NREQ-1:0]  repend;
    logic             retrig;
    logic             cancel_owner;
    logic             req_owner;
    logic [IDX_W-1:0] own_req_idx;

    // A request cancelled in the same cycle is never eligible for a grant.
    assign eligible     = pending_q & ~bus.cancel;
    assign cancel_owner = |(bus.cancel & owner_q);
    assign req_owner    = |(bus.req & owner_q & ~bus.cancel);

    timer_arbiter_prio_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_prio_pick (
        .vec    (eligible),
        .onehot (pick_oh),
        .index  (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        own_req_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q[i]) begin
                own_req_idx = bus.req_idx[i*IDX_W +: IDX_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        interval_d = interval_q;
        first_d    = 1'b0;
        grant_clr  = '0;
        repend     = '0;
        retrig     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    owner_d    = pick_oh;
                    interval_d = idx_q[pick_idx];
                    grant_clr  = pick_oh;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                if (cancel_owner) begin
                    owner_d = '0;
                    state_d = StIdle;
                end else begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (cancel_owner) begin
                    owner_d = '0;
                    state_d = StIdle;
                end else if (bus.param_value == '0) begin
                    state_d = StDone;
                end else begin
                    first_d = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cancel_owner) begin
                    owner_d = '0;
                    state_d = StIdle;
                end else if (req_owner) begin
                    retrig     = 1'b1;
                    interval_d = own_req_idx;
                    state_d    = StFetch;
`ifdef TIMER_ARB_PREEMPT_EN
                end else if (pick_any && ((pick_oh & (owner_q - NREQ'(1))) != '0)) begin
                    repend     = owner_q;
                    owner_d    = pick_oh;
                    interval_d = idx_q[pick_idx];
                    grant_clr  = pick_oh;
                    state_d    = StFetch;
`endif
                end else if (!first_q && bus.timer_expired) begin
                    // First RUN cycle still sees the previous run's expired level.
                    state_d = StDone;
                end
            end
            StDone: begin
                owner_d = '0;
                state_d = StIdle;
            end
            default: begin
                owner_d = '0;
                state_d = StIdle;
            end
        endcase

        pending_d = ((pending_q & ~grant_clr) | repend | (bus.req & ~(retrig ? owner_q : '0)))
                    & ~bus.cancel;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            owner_q    <= '0;
            interval_q <= '0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            owner_q    <= owner_d;
            interval_q <= interval_d;
            first_q    <= first_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req[i] && !bus.cancel[i]) begin
                    idx_q[i] <= bus.req_idx[i*IDX_W +: IDX_W];
                end
            end
        end
    end

    assign bus.start_timer = (state_q == StLoad) && !cancel_owner && (bus.param_value != '0);
    assign bus.load_value  = bus.start_timer ? bus.param_value : '0;
    assign bus.done        = (state_q == StDone) ? owner_q : '0;
    assign bus.busy        = (state_q != StIdle);
    assign bus.owner       = owner_q;
    assign bus.interval    = interval_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed scenarios plus random traffic against a rule-level model.
module tb_timer_arbiter;

    localparam int NREQ  = 4;
    localparam int IDX_W = 2;
    localparam int VAL_W = 4;

    localparam int PH_IDLE  = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_LOAD  = 2;
    localparam int PH_RUN   = 3;
    localparam int PH_DONE  = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    timer_arbiter_if #(.NREQ(NREQ), .IDX_W(IDX_W), .VAL_W(VAL_W)) bus ();

    timer_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W), .VAL_W(VAL_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Environment: registered parameter table and a countdown timer with a lagging expired flag.
    logic [VAL_W-1:0] tbl [4];
    logic [VAL_W-1:0] tmr_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.param_value   <= '0;
            bus.timer_expired <= 1'b0;
            tmr_cnt           <= '0;
        end else begin
            bus.param_value   <= tbl[bus.interval];
            bus.timer_expired <= (tmr_cnt == '0);
            if (bus.start_timer) tmr_cnt <= bus.load_value;
            else if (tmr_cnt != '0) tmr_cnt <= tmr_cnt - 1'b1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_start = -1;
    int start_cnt = 0;
    int done_q[$];

    int m_ph, m_cur, m_int, m_age;
    bit m_pend [4];
    int m_lidx [4];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ph  = PH_IDLE;
        m_cur = -1;
        m_int = 0;
        m_age = 0;
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0;
            m_lidx[i] = 0;
        end
    endtask

    task automatic model_eval(input logic [3:0] r, input logic [3:0] c, input logic [7:0] ri);
        int e_own, e_done, e_start, v, old_cur, hi;
        bit retrig;
        v       = int'(tbl[m_int]);
        e_own   = (m_cur >= 0) ? (1 << m_cur) : 0;
        e_done  = (m_ph == PH_DONE) ? e_own : 0;
        e_start = (m_ph == PH_LOAD && m_cur >= 0 && !c[m_cur] && v != 0) ? 1 : 0;
        check_eq("owner", int'(bus.owner), e_own);
        check_eq("busy", int'(bus.busy), (m_ph != PH_IDLE) ? 1 : 0);
        check_eq("interval", int'(bus.interval), m_int);
        check_eq("done", int'(bus.done), e_done);
        check_eq("start_timer", int'(bus.start_timer), e_start);
        check_eq("load_value", int'(bus.load_value), e_start ? v : 0);
        if (bus.start_timer) begin
            last_start = cyc;
            start_cnt++;
        end
        if (bus.done != '0) done_q.push_back(int'(bus.done));

        retrig  = 0;
        old_cur = m_cur;
        hi      = -1;
        case (m_ph)
            PH_IDLE: begin
                for (int i = 0; i < 4; i++) begin
                    if (hi < 0 && m_pend[i] && !c[i]) hi = i;
                end
                if (hi >= 0) begin
                    m_cur      = hi;
                    m_int      = m_lidx[hi];
                    m_pend[hi] = 0;
                    m_ph       = PH_FETCH;
                end
            end
            PH_FETCH, PH_LOAD: begin
                if (c[m_cur]) begin
                    m_cur = -1;
                    m_ph  = PH_IDLE;
                end else if (m_ph == PH_FETCH) m_ph = PH_LOAD;
                else if (v == 0) m_ph = PH_DONE;
                else begin
                    m_ph  = PH_RUN;
                    m_age = 0;
                end
            end
            PH_RUN: begin
`ifdef TIMER_ARB_PREEMPT_EN
                for (int i = 0; i < m_cur; i++) begin
                    if (hi < 0 && m_pend[i] && !c[i]) hi = i;
                end
`endif
                if (c[m_cur]) begin
                    m_cur = -1;
                    m_ph  = PH_IDLE;
                end else if (r[m_cur]) begin
                    retrig = 1;
                    m_int  = int'((ri >> (2 * m_cur)) & 8'h3);
                    m_ph   = PH_FETCH;
                end else if (hi >= 0) begin
                    m_pend[m_cur] = 1;
                    m_cur         = hi;
                    m_pend[hi]    = 0;
                    m_int         = m_lidx[hi];
                    m_ph          = PH_FETCH;
                end else if (m_age > 0 && bus.timer_expired) begin
                    m_ph = PH_DONE;
                end
                m_age++;
            end
            default: begin
                m_cur = -1;
                m_ph  = PH_IDLE;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            if (c[i]) m_pend[i] = 0;
            else if (r[i]) begin
                m_lidx[i] = int'((ri >> (2 * i)) & 8'h3);
                if (!(retrig && i == old_cur)) m_pend[i] = 1;
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] c, input logic [7:0] ri);
        @(posedge clock);
        #2;
        bus.req     = r;
        bus.cancel  = c;
        bus.req_idx = ri;
        #2;
        model_eval(r, c, ri);
        cyc++;
    endtask

    function automatic bit model_quiet();
        return m_ph == PH_IDLE && !(m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3]);
    endfunction

    task automatic wait_idle(input int bound);
        int n = 0;
        while (!model_quiet() && n < bound) begin
            step(4'b0, 4'b0, 8'h0);
            n++;
        end
        step(4'b0, 4'b0, 8'h0);
        check_eq("wait_idle_busy", int'(bus.busy), 0);
    endtask

    task automatic wait_run(input int bound);
        int n = 0;
        while (m_ph != PH_RUN && n < bound) begin
            step(4'b0, 4'b0, 8'h0);
            n++;
        end
        check_eq("wait_run_reached", int'(bus.busy), 1);
    endtask

    initial begin
        logic [3:0] r, c;
        int req_cyc;
        bus.req     = '0;
        bus.cancel  = '0;
        bus.req_idx = '0;
        tbl[0] = 4'd6;
        tbl[1] = 4'd5;
        tbl[2] = 4'd0;
        tbl[3] = 4'd3;
        model_reset();
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        step(4'b0, 4'b0, 8'h0);

        // Single request: start_timer three cycles after the request.
        req_cyc = cyc;
        step(4'b0010, 4'b0, 8'h00);
        repeat (5) step(4'b0, 4'b0, 8'h0);
        check_eq("latency", last_start - req_cyc, 3);
        done_q.delete();
        wait_idle(40);
        check_eq("single_done_cnt", done_q.size(), 1);
        if (done_q.size() > 0) check_eq("single_done_owner", done_q[0], 2);

        // Simultaneous req[0] (idx 1) and req[2] (idx 3).
        done_q.delete();
        step(4'b0101, 4'b0, 8'h31);
        wait_idle(80);
        check_eq("simul_done_cnt", done_q.size(), 2);
        if (done_q.size() == 2) begin
            check_eq("simul_first", done_q[0], 1);
            check_eq("simul_second", done_q[1], 4);
        end

        // Zero table value: no timer start.
        done_q.delete();
        start_cnt = 0;
        step(4'b0001, 4'b0, 8'h02);
        wait_idle(20);
        check_eq("zero_starts", start_cnt, 0);
        check_eq("zero_done_cnt", done_q.size(), 1);

        // Cancel in RUN, then cancel + request on the same index.
        done_q.delete();
        step(4'b0010, 4'b0, 8'h04);
        wait_run(10);
        step(4'b0, 4'b0010, 8'h0);
        step(4'b0100, 4'b0100, 8'h30);
        wait_idle(30);
        check_eq("cancel_done_cnt", done_q.size(), 0);

        // Retrigger the owner in RUN with index 3.
        done_q.delete();
        step(4'b0010, 4'b0, 8'h04);
        wait_run(10);
        step(4'b0010, 4'b0, 8'h0C);
        check_eq("retrig_busy", int'(bus.busy), 1);
        wait_idle(40);
        check_eq("retrig_done_cnt", done_q.size(), 1);

        // Higher-priority request while owner=0010 is running.
        done_q.delete();
        step(4'b0010, 4'b0, 8'h04);
        wait_run(10);
        step(4'b0001, 4'b0, 8'h00);
        wait_idle(80);
        check_eq("prio_done_cnt", done_q.size(), 2);
        if (done_q.size() == 2) begin
`ifdef TIMER_ARB_PREEMPT_EN
            check_eq("prio_first", done_q[0], 1);
            check_eq("prio_second", done_q[1], 2);
`else
            check_eq("prio_first", done_q[0], 2);
            check_eq("prio_second", done_q[1], 1);
`endif
        end

        // Reset while running: outputs clear immediately, no done afterwards.
        step(4'b0010, 4'b0, 8'h04);
        wait_run(10);
        @(posedge clock);
        #2 reset = 1'b1;
        bus.req = '0;
        #1;
        check_eq("rst_busy", int'(bus.busy), 0);
        check_eq("rst_owner", int'(bus.owner), 0);
        check_eq("rst_done", int'(bus.done), 0);
        check_eq("rst_start", int'(bus.start_timer), 0);
        check_eq("rst_interval", int'(bus.interval), 0);
        model_reset();
        @(posedge clock);
        #2 reset = 1'b0;
        done_q.delete();
        repeat (12) step(4'b0, 4'b0, 8'h0);
        check_eq("rst_no_done", done_q.size(), 0);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            if (k % 250 == 0 && m_ph == PH_IDLE) begin
                for (int t = 0; t < 4; t++) tbl[t] = VAL_W'($urandom_range(0, 6));
            end
            r = '0;
            c = '0;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) == 0) r[i] = 1'b1;
                if ($urandom_range(0, 39) == 0) c[i] = 1'b1;
            end
            step(r, c, 8'($urandom));
        end
        wait_idle(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
